// File: rtl/pmu_ahb_arb_pkg.sv
// Shared types and AHB-lite encodings for the PMU register-access arbiter.
package pmu_ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    function automatic logic [IW-1:0] slot(input logic [IW-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= N) j = j - N;
        return IW'(j);
    endfunction

    // Scan from the farthest slot back toward ptr so the nearest hit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[slot(ptr, k)]) begin
                idx = slot(ptr, k);
                any = 1'b1;
            end
        end
        gnt = '0;
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/pmu_ahb_arbiter.sv
// Round-robin AHB-lite master serializing single-word PMU register accesses
// from N_REQ requesters, with a per-phase watchdog against a hung slave.
module pmu_ahb_arbiter
    import pmu_ahb_arb_pkg::*;
#(
    parameter int          N_REQ      = 4,
    parameter int          DATA_WIDTH = 32,
    parameter int          OFF_W      = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h8010_0000,
    parameter int          TIMEOUT    = 255
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ-1:0]            we_i,
    input  logic [N_REQ*OFF_W-1:0]      offset_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [N_REQ-1:0]            done_o,
    output logic                        err_o,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    output logic                        hsel_o,
    output logic [31:0]                 haddr_o,
    output logic                        hwrite_o,
    output logic [1:0]                  htrans_o,
    output logic [2:0]                  hsize_o,
    output logic [2:0]                  hburst_o,
    output logic [DATA_WIDTH-1:0]       hwdata_o,
    input  logic                        hready_i,
    input  logic [1:0]                  hresp_i,
    input  logic [DATA_WIDTH-1:0]       hrdata_i
);

    localparam int             IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t                  state, state_nxt;
    logic [IW-1:0]           ptr, ptr_nxt;
    logic [N_REQ-1:0]        owner, owner_nxt;
    logic                    we_q, we_nxt;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
    logic [WDW-1:0]          wdog, wdog_nxt;

    logic [N_REQ-1:0]        gnt_nxt, done_nxt;
    logic                    err_nxt, hsel_nxt, hwrite_nxt;
    logic [DATA_WIDTH-1:0]   rdata_nxt, hwdata_nxt;
    logic [31:0]             haddr_nxt;
    logic [1:0]              htrans_nxt;

    logic [N_REQ-1:0]        arb_gnt;
    logic [IW-1:0]           arb_idx;
    logic                    arb_any;
    logic [OFF_W-1:0]        arb_off;
    logic                    wd_expire;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req (req_i),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign arb_off   = offset_i[int'(arb_idx)*OFF_W +: OFF_W];
    // This low cycle is the TIMEOUT-th consecutive one in the current phase.
    assign wd_expire = !hready_i && (wdog == WD_LAST);
    assign hsize_o   = HSIZE_WORD;
    assign hburst_o  = HBURST_SINGLE;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        owner_nxt  = owner;
        we_nxt     = we_q;
        wdata_nxt  = wdata_q;
        wdog_nxt   = wdog;
        gnt_nxt    = '0;
        done_nxt   = '0;
        err_nxt    = 1'b0;
        rdata_nxt  = '0;
        hsel_nxt   = hsel_o;
        haddr_nxt  = haddr_o;
        hwrite_nxt = hwrite_o;
        htrans_nxt = htrans_o;
        hwdata_nxt = hwdata_o;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    owner_nxt  = arb_gnt;
                    we_nxt     = we_i[arb_idx];
                    wdata_nxt  = wdata_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                    hsel_nxt   = 1'b1;
                    htrans_nxt = HTRANS_NONSEQ;
                    haddr_nxt  = BASE_ADDR + {{(30-OFF_W){1'b0}}, arb_off, 2'b00};
                    hwrite_nxt = we_i[arb_idx];
                    ptr_nxt    = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
                    wdog_nxt   = '0;
                    state_nxt  = ADDR;
                end
            end
            ADDR, DATA: begin
                if (hready_i) begin
                    wdog_nxt = '0;
                    if (state == ADDR) begin
                        gnt_nxt    = owner;
                        hsel_nxt   = 1'b0;
                        htrans_nxt = HTRANS_IDLE;
                        hwdata_nxt = we_q ? wdata_q : '0;
                        state_nxt  = DATA;
                    end else begin
                        done_nxt   = owner;
                        rdata_nxt  = we_q ? '0 : hrdata_i;
                        err_nxt    = (hresp_i == HRESP_ERROR);
                        hwdata_nxt = '0;
                        state_nxt  = IDLE;
                    end
                end else if (wd_expire) begin
                    // Abort: report an error completion and release the bus.
                    wdog_nxt   = '0;
                    done_nxt   = owner;
                    err_nxt    = 1'b1;
                    hsel_nxt   = 1'b0;
                    htrans_nxt = HTRANS_IDLE;
                    hwdata_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wdog     <= '0;
            gnt_o    <= '0;
            done_o   <= '0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
            hsel_o   <= 1'b0;
            haddr_o  <= '0;
            hwrite_o <= 1'b0;
            htrans_o <= HTRANS_IDLE;
            hwdata_o <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            we_q     <= we_nxt;
            wdata_q  <= wdata_nxt;
            wdog     <= wdog_nxt;
            gnt_o    <= gnt_nxt;
            done_o   <= done_nxt;
            err_o    <= err_nxt;
            rdata_o  <= rdata_nxt;
            hsel_o   <= hsel_nxt;
            haddr_o  <= haddr_nxt;
            hwrite_o <= hwrite_nxt;
            htrans_o <= htrans_nxt;
            hwdata_o <= hwdata_nxt;
        end
    end

endmodule

// File: tb/tb_pmu_ahb_arbiter.sv
// Scoreboard bench: a spec-level RR/memory model queues expected grants, address
// phases and completions; a monitor pops and compares as the DUT presents them.
module tb_pmu_ahb_arbiter;

    localparam int          N    = 4;
    localparam int          OW   = 6;
    localparam int          DW   = 32;
    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h8010_0000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req = '0, we = '0;
    logic [N*OW-1:0] offset = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt_o, done_o;
    logic            err_o, hsel_o, hwrite_o;
    logic [DW-1:0]   rdata_o, hwdata_o;
    logic [31:0]     haddr_o;
    logic [1:0]      htrans_o;
    logic [2:0]      hsize_o, hburst_o;
    logic            hready = 1'b1;
    logic [1:0]      hresp = 2'b00;
    logic [DW-1:0]   hrdata = '0;

    pmu_ahb_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .OFF_W(OW), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .we_i(we), .offset_i(offset), .wdata_i(wdata),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .hsel_o(hsel_o), .haddr_o(haddr_o), .hwrite_o(hwrite_o), .htrans_o(htrans_o),
        .hsize_o(hsize_o), .hburst_o(hburst_o), .hwdata_o(hwdata_o),
        .hready_i(hready), .hresp_i(hresp), .hrdata_i(hrdata)
    );

    typedef struct { int idx; int cyc; logic [31:0] hwdata; } gexp_t;
    typedef struct { int idx; int cyc; bit err; logic [31:0] rdata; } dexp_t;
    typedef struct { logic [31:0] addr; bit wr; } aexp_t;

    gexp_t gq[$];
    dexp_t dq[$];
    aexp_t aq[$];

    int checks = 0, errors = 0, cyc = 0, mptr = 0;
    logic [31:0] mmem [64];
    logic [31:0] smem [64];
    bit stuck = 0, rand_waits = 0;
    int fixed_dw = 0;
    logic [N-1:0] bwe;
    logic [OW-1:0] boff [N];
    logic [31:0] bwd [N];
    bit hold_mode = 0;
    int hold_k = 0, gcount = 0;

    initial forever @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++)
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    // Monitor
    initial begin
        gexp_t g; dexp_t d; aexp_t a;
        logic hsel_prev;
        hsel_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt_o != '0) begin
                if (gq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL gnt_unexpected: got %b with none outstanding", gnt_o);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_vec", 32'(gnt_o), 32'(1) << g.idx);
                    if (g.cyc >= 0) chk("gnt_cycle", cyc, g.cyc);
                    chk("gnt_hwdata", hwdata_o, g.hwdata);
                end
            end
            if (done_o != '0) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got %b with none outstanding", done_o);
                end else begin
                    d = dq.pop_front();
                    chk("done_vec", 32'(done_o), 32'(1) << d.idx);
                    chk("done_err", 32'(err_o), 32'(d.err));
                    chk("done_rdata", rdata_o, d.rdata);
                    chk("done_hsel", 32'(hsel_o), 32'd0);
                    if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
                end
            end
            if (hsel_o && !hsel_prev) begin
                if (aq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL addr_unexpected: got %h with none outstanding", haddr_o);
                end else begin
                    a = aq.pop_front();
                    chk("haddr", haddr_o, a.addr);
                    chk("hwrite", 32'(hwrite_o), 32'(a.wr));
                    chk("htrans", 32'(htrans_o), 32'h2);
                end
            end
            hsel_prev = hsel_o;
        end
    end

    // Slave: word memory with wait states; offsets >= 47 answer a two-cycle ERROR.
    initial begin
        bit act, w, e;
        int dw, aw, est, off;
        act = 0; aw = -1; w = 0; e = 0; dw = 0; est = 0; off = 0;
        forever begin
            @(negedge clk);
            hrdata = $urandom;
            hresp  = 2'b00;
            if (!rstn) begin
                act = 0; aw = -1; hready = 1'b1;
            end else if (act) begin
                if (e) begin
                    hresp = 2'b01;
                    if (est == 0) begin hready = 1'b0; est = 1; end
                    else begin hready = 1'b1; hrdata = '0; act = 0; end
                end else if (dw > 0) begin
                    hready = 1'b0; dw--;
                end else begin
                    hready = 1'b1; act = 0;
                    if (w) smem[off] = hwdata_o;
                    else   hrdata = smem[off];
                end
            end else if (hsel_o && htrans_o == 2'b10) begin
                if (stuck) hready = 1'b0;
                else begin
                    if (aw < 0) aw = rand_waits ? int'($urandom_range(0, 2)) : 0;
                    if (aw > 0) begin hready = 1'b0; aw--; end
                    else begin
                        hready = 1'b1; aw = -1; act = 1; w = hwrite_o;
                        off = int'(((haddr_o - BASE) >> 2) & 32'h3F);
                        e = (off >= 47); est = 0;
                        dw = rand_waits ? int'($urandom_range(0, 3)) : fixed_dw;
                    end
                end
            end else begin
                hready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (hold_mode) begin
            if (gnt_o != '0) begin
                gcount++;
                if (gcount >= hold_k) req = '0;
            end
        end else begin
            req = req & ~(gnt_o | done_o);
        end
    endtask

    task automatic drive_bufs();
        for (int i = 0; i < N; i++) begin
            we[i] = bwe[i];
            offset[i*OW +: OW] = boff[i];
            wdata[i*DW +: DW] = bwd[i];
        end
    endtask

    // Model the whole batch at issue time, then drive it and wait for completions.
    task automatic run_batch(input logic [N-1:0] mask, input bit hold, input int k,
                             input int g_lat, input int d_lat, input bit abort);
        logic [N-1:0] pend;
        int n, pick, budget;
        bit e;
        gexp_t g; dexp_t d; aexp_t a;
        pend = mask;
        n = hold ? k : $countones(mask);
        for (int t = 0; t < n; t++) begin
            pick = rr_pick(pend, mptr);
            e = abort || (boff[pick] >= 47);
            a.addr = BASE + 32'(boff[pick]) * 4; a.wr = bwe[pick];
            aq.push_back(a);
            if (!abort) begin
                g.idx = pick; g.cyc = (t == 0 && g_lat >= 0) ? cyc + g_lat : -1;
                g.hwdata = bwe[pick] ? bwd[pick] : 32'd0;
                gq.push_back(g);
            end
            d.idx = pick; d.cyc = (t == 0 && d_lat >= 0) ? cyc + d_lat : -1;
            d.err = e; d.rdata = (bwe[pick] || e) ? 32'd0 : mmem[boff[pick]];
            if (bwe[pick] && !e) mmem[boff[pick]] = bwd[pick];
            dq.push_back(d);
            if (!hold) pend[pick] = 1'b0;
            mptr = (pick + 1) % N;
        end
        drive_bufs();
        hold_mode = hold; hold_k = k; gcount = 0;
        req = mask;
        budget = 100 + 60 * n;
        while (dq.size() != 0 && budget > 0) begin tick(); budget--; end
        if (dq.size() != 0) begin
            checks++; errors++;
            $display("FAIL batch_timeout: %0d completions still outstanding", dq.size());
            dq.delete(); gq.delete(); aq.delete();
            req = '0;
        end
        tick(); tick();
    endtask

    initial begin
        int b;
        gexp_t g; aexp_t a;
        for (int i = 0; i < 64; i++) begin mmem[i] = $urandom; smem[i] = mmem[i]; end
        mmem[43] = 32'hCAFE_CAFE; smem[43] = 32'hCAFE_CAFE;
        for (int i = 0; i < N; i++) begin boff[i] = '0; bwd[i] = '0; end
        bwe = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 0);     chk("rst_done", 32'(done_o), 0);
        chk("rst_hsel", 32'(hsel_o), 0);   chk("rst_haddr", haddr_o, 0);
        chk("rst_htrans", 32'(htrans_o), 0); chk("rst_hsize", 32'(hsize_o), 32'h2);
        chk("rst_hburst", 32'(hburst_o), 0); chk("rst_hwdata", hwdata_o, 0);
        rstn = 1'b1;
        tick(); tick();

        // Single write, minimum latency
        bwe = 4'b0001; boff[0] = 6'd0; bwd[0] = 32'd2;
        run_batch(4'b0001, 0, 0, 2, 3, 0);
        // Read of offset 0x2B
        bwe = 4'b0000; boff[1] = 6'h2B;
        run_batch(4'b0010, 0, 0, 2, 3, 0);
        // Contention with requests held
        for (int i = 0; i < N; i++) boff[i] = 6'(i + 1);
        run_batch(4'b1111, 1, 5, -1, -1, 0);
        run_batch(4'b0101, 1, 3, -1, -1, 0);
        // Data-phase wait states
        fixed_dw = 3; boff[3] = 6'd5;
        run_batch(4'b1000, 0, 0, 2, 6, 0);
        fixed_dw = 0;
        // Two-cycle ERROR, then clean write and read-back
        boff[0] = 6'd50;
        run_batch(4'b0001, 0, 0, 2, 4, 0);
        bwe = 4'b0010; boff[1] = 6'd9; bwd[1] = 32'h1234_5678;
        run_batch(4'b0010, 0, 0, 2, 3, 0);
        bwe = 4'b0000; boff[2] = 6'd9;
        run_batch(4'b0100, 0, 0, 2, 3, 0);
        // Watchdog abort in address phase
        stuck = 1; boff[2] = 6'd4;
        run_batch(4'b0100, 0, 0, -1, TO + 1, 1);
        stuck = 0;

        // Reset during data phase kills the transfer silently
        fixed_dw = 5; bwe = '0; boff[2] = 6'd7;
        a.addr = BASE + 32'd28; a.wr = 1'b0; aq.push_back(a);
        g.idx = 2; g.cyc = -1; g.hwdata = 32'd0; gq.push_back(g);
        drive_bufs(); hold_mode = 0; req = 4'b0100;
        b = 40;
        while (gq.size() != 0 && b > 0) begin tick(); b--; end
        if (gq.size() != 0) begin
            checks++; errors++;
            $display("FAIL rst_setup: grant never seen, %0d outstanding", gq.size());
            gq.delete(); aq.delete();
        end
        tick();
        rstn = 1'b0;
        #1;
        chk("mid_rst_done", 32'(done_o), 0); chk("mid_rst_hsel", 32'(hsel_o), 0);
        chk("mid_rst_haddr", haddr_o, 0);    chk("mid_rst_htrans", 32'(htrans_o), 0);
        chk("mid_rst_hwdata", hwdata_o, 0);  chk("mid_rst_rdata", rdata_o, 0);
        chk("mid_rst_err", 32'(err_o), 0);   chk("mid_rst_gnt", 32'(gnt_o), 0);
        req = '0;
        tick(); tick(); tick();
        rstn = 1'b1; mptr = 0; fixed_dw = 0;
        tick();
        run_batch(4'b1111, 0, 0, -1, -1, 0);

        // Randomized batches
        rand_waits = 1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                bwe[i] = 1'($urandom_range(0, 1));
                boff[i] = 6'($urandom_range(0, 63));
                bwd[i] = $urandom;
            end
            run_batch(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 6)), -1, -1, 0);
        end

        if (gq.size() != 0 || aq.size() != 0) begin
            checks++; errors++;
            $display("FAIL leftover: %0d grants %0d addresses never seen", gq.size(), aq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
